// File: rtl/uart_rx_port.sv
// ============================================================================
// Module   : uart_rx_port
// Brief    : 8N1 UART receiver with a byte FIFO and a small register port
//            (DATA at word 0, STATUS / error-clear at word 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_port #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        rx,
    input  logic        sel,
    input  logic        wen,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rx_avail
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam int c_depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_cnt = (DEPTH_LOG2 + 1)'(c_depth);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic                  rx_meta_q, rx_sync_q;
    state_t                state_q, state_d;
    logic [c_cnt_w-1:0]    cyc_q, cyc_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  stop_ok, stop_bad;

    logic [7:0]            mem_q [c_depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                  rd0_q, rd0_d, rx_avail_q;
    logic                  full, not_empty, pop, push_ok, ovr_evt, stat_wr;
    logic                  unused_wdata;

    assign unused_wdata = ^{wdata[31:4], wdata[1:0]};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    cyc_d   = '0;
                end
            end
            ST_START: begin
                // Re-check the line at mid start bit so short glitches are ignored
                if (cyc_q == c_half_last) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    cyc_d = cyc_q + c_cnt_w'(1);
                end
            end
            ST_DATA: begin
                if (cyc_q == c_bit_last) begin
                    cyc_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + c_cnt_w'(1);
                end
            end
            ST_STOP: begin
                if (cyc_q == c_bit_last) begin
                    cyc_d    = '0;
                    state_d  = ST_IDLE;
                    stop_ok  = rx_sync_q;
                    stop_bad = !rx_sync_q;
                end else begin
                    cyc_d = cyc_q + c_cnt_w'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == c_full_cnt);
        rd0_d     = sel & ~wen & (addr == 2'd0);
        pop       = rd0_d & ~rd0_q & not_empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept
        push_ok   = stop_ok & (~full | pop);
        ovr_evt   = stop_ok & full & ~pop;
        stat_wr   = sel & wen & (addr == 2'd1);

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        overrun_d = overrun_q;
        if (ovr_evt) begin
            overrun_d = 1'b1;
        end else if (stat_wr && wdata[2]) begin
            overrun_d = 1'b0;
        end

        frame_err_d = frame_err_q;
        if (stop_bad) begin
            frame_err_d = 1'b1;
        end else if (stat_wr && wdata[3]) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rd0_q       <= 1'b0;
            rx_avail_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rd0_q       <= rd0_d;
            rx_avail_q  <= (count_d != '0);
        end
    end

    // Storage is left unreset; it is only visible through rdata when count is nonzero
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                2'd0: begin
                    if (not_empty) begin
                        rdata[7:0] = mem_q[rd_ptr_q];
                    end
                end
                2'd1: begin
                    rdata[0]              = not_empty;
                    rdata[1]              = full;
                    rdata[2]              = overrun_q;
                    rdata[3]              = frame_err_q;
                    rdata[DEPTH_LOG2+8:8] = count_q;
                end
                default: rdata = '0;
            endcase
        end
    end

    assign rx_avail = rx_avail_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_port.sv
// ============================================================================
// Module   : tb_uart_rx_port
// Brief    : Directed bench for uart_rx_port against a frame-level FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_port;

    logic        clk;
    logic        nreset;
    logic        rx;
    logic        sel;
    logic        wen;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx_avail;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    logic       m_ovr;
    logic       m_ferr;
    logic       model_valid;

    uart_rx_port #(
        .CLKS_PER_BIT(16),
        .DEPTH_LOG2  (3)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .rx      (rx),
        .sel     (sel),
        .wen     (wen),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rx_avail(rx_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (mq.size() != 0);
        s[1]     = (mq.size() == 8);
        s[2]     = m_ovr;
        s[3]     = m_ferr;
        s[11:8]  = 4'(mq.size());
        return s;
    endfunction

    function automatic logic [31:0] model_rdata();
        if (!sel) return 32'h0;
        case (addr)
            2'd0:    return (mq.size() != 0) ? {24'h0, mq[0]} : 32'h0;
            2'd1:    return model_status();
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (model_valid && nreset) begin
            check("rx_avail", {31'h0, rx_avail}, {31'h0, mq.size() != 0});
            if (!(sel && wen)) check("rdata", rdata, model_rdata());
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        model_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            cycles(16);
        end
        rx = 1'b1;
        cycles(4);
        if (!stop_bit)           m_ferr = 1'b1;
        else if (mq.size() < 8)  mq.push_back(b);
        else                     m_ovr = 1'b1;
        model_valid = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        sel  = 1'b1;
        wen  = 1'b0;
        addr = a;
        @(negedge clk);
        v = rdata;
        cycles(1);
        if (a == 2'd0 && mq.size() != 0) void'(mq.pop_front());
        sel = 1'b0;
        cycles(1);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        sel   = 1'b1;
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        cycles(1);
        if (a == 2'd1) begin
            if (d[2]) m_ovr  = 1'b0;
            if (d[3]) m_ferr = 1'b0;
        end
        sel   = 1'b0;
        wen   = 1'b0;
        wdata = '0;
        cycles(1);
    endtask

    initial begin
        logic [31:0] v;
        nreset = 1'b0; rx = 1'b1; sel = 1'b0; wen = 1'b0; addr = 2'd0; wdata = '0;
        mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0; model_valid = 1'b0;
        cycles(3);
        nreset = 1'b1;
        model_valid = 1'b1;
        cycles(2);

        // Reset state
        read_reg(2'd1, v); check("reset_status", v, 32'h0);
        read_reg(2'd0, v); check("reset_data_empty", v, 32'h0);
        check("reset_rx_avail", {31'h0, rx_avail}, 32'h0);

        // Single valid byte
        send_frame(8'hA5, 1'b1);
        check("a5_rx_avail", {31'h0, rx_avail}, 32'h1);
        read_reg(2'd1, v); check("a5_status", v, 32'h101);
        read_reg(2'd0, v); check("a5_data", v, 32'h0000_00A5);
        read_reg(2'd1, v); check("a5_status_after", v, 32'h0);

        // Start-bit glitch
        rx = 1'b0; cycles(4); rx = 1'b1; cycles(30);
        read_reg(2'd1, v); check("glitch_status", v, 32'h0);

        // Overrun: 9 bytes into 8 slots
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        read_reg(2'd1, v); check("ovr_status", v, 32'h807);
        write_reg(2'd0, 32'hFF);
        read_reg(2'd2, v); check("addr2_zero", v, 32'h0);
        read_reg(2'd3, v); check("addr3_zero", v, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            read_reg(2'd0, v); check("ovr_drain", v, 32'(i));
        end
        read_reg(2'd1, v); check("ovr_status_drained", v, 32'h004);
        write_reg(2'd1, 32'h4);
        read_reg(2'd1, v); check("ovr_cleared", v, 32'h0);

        // Framing error then good frame
        send_frame(8'h3C, 1'b0);
        read_reg(2'd1, v); check("ferr_status", v, 32'h008);
        send_frame(8'h3C, 1'b1);
        read_reg(2'd1, v); check("ferr_then_good", v, 32'h109);
        read_reg(2'd0, v); check("ferr_good_data", v, 32'h3C);
        write_reg(2'd1, 32'h8);
        read_reg(2'd1, v); check("ferr_cleared", v, 32'h0);

        // Held read pops once
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        sel = 1'b1; wen = 1'b0; addr = 2'd0;
        cycles(1);
        void'(mq.pop_front());
        cycles(4);
        sel = 1'b0;
        cycles(1);
        read_reg(2'd1, v); check("held_status", v, 32'h101);
        read_reg(2'd0, v); check("held_data", v, 32'h22);

        // Reset during DATA bit 4, with a byte already queued
        send_frame(8'h99, 1'b1);
        model_valid = 1'b0;
        rx = 1'b0; cycles(16);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0); cycles(16);
        end
        rx = 1'b0; cycles(5);
        sel = 1'b1; addr = 2'd1;
        nreset = 1'b0;
        #1;
        check("async_rst_avail", {31'h0, rx_avail}, 32'h0);
        check("async_rst_status", rdata, 32'h0);
        sel = 1'b0;
        cycles(3);
        nreset = 1'b1;
        rx = 1'b1;
        mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        cycles(40);
        model_valid = 1'b1;
        send_frame(8'h7E, 1'b1);
        read_reg(2'd1, v); check("rst_status", v, 32'h101);
        read_reg(2'd0, v); check("rst_data", v, 32'h7E);

        cycles(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
